// File: rtl/ahb_gpio_param_if.sv
// AHB-Lite slave-side bus bundle for the parameterised GPIO block.
`timescale 1ns/1ps
interface ahb_gpio_param_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        input  HRDATA, HREADYOUT
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        output HRDATA, HREADYOUT
    );
endinterface

// File: rtl/ahb_gpio_param.sv
// Parameterised AHB-Lite GPIO slave: per-bit direction, synchronised inputs,
// edge-detect interrupts with enable, polarity and write-1-to-clear status.
`timescale 1ns/1ps
module ahb_gpio_param #(
    parameter int unsigned GPIO_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_gpio_param_if.slave       ahb,
    input  logic [GPIO_WIDTH-1:0] GPIOIN,
    output logic [GPIO_WIDTH-1:0] GPIOOUT,
    output logic [GPIO_WIDTH-1:0] GPIODIR,
    output logic                  GPIOIRQ
);
    localparam int unsigned W = GPIO_WIDTH;

    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_DIR  = 3'd1;
    localparam logic [2:0] REG_EN   = 3'd2;
    localparam logic [2:0] REG_POL  = 3'd3;
    localparam logic [2:0] REG_STAT = 3'd4;

    logic        addr_valid_q, addr_valid_d;
    logic [4:0]  addr_q, addr_d;
    logic        write_q, write_d;
    logic [2:0]  size_q, size_d;

    logic [W-1:0] out_q, out_d;
    logic [W-1:0] dir_q, dir_d;
    logic [W-1:0] en_q, en_d;
    logic [W-1:0] pol_q, pol_d;
    logic [W-1:0] stat_q, stat_d;
    logic [W-1:0] prev_q, prev_d;
    logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;

    logic [W-1:0] sync_val, evt, wmask, wdata, clr;
    logic [3:0]   lanes;
    logic [31:0]  lane_mask;
    logic [31:0]  rdata;
    logic         wr_en;
    logic         unused_ok;

    // Address phase capture; any completed address phase refreshes the flag
    always_comb begin
        addr_valid_d = addr_valid_q;
        addr_d       = addr_q;
        write_d      = write_q;
        size_d       = size_q;
        if (ahb.HREADY) begin
            addr_valid_d = ahb.HSEL & ahb.HTRANS[1];
            if (ahb.HSEL && ahb.HTRANS[1]) begin
                addr_d  = ahb.HADDR[4:0];
                write_d = ahb.HWRITE;
                size_d  = ahb.HSIZE;
            end
        end
    end

    // Little-endian byte lanes; oversize transfers behave as words
    always_comb begin
        case (size_q)
            3'd0:    lanes = 4'b0001 << addr_q[1:0];
            3'd1:    lanes = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
        lane_mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    end

    assign wr_en    = addr_valid_q & write_q & ahb.HREADY;
    assign wmask    = lane_mask[W-1:0] & {W{wr_en}};
    assign wdata    = ahb.HWDATA[W-1:0];
    assign sync_val = sync_q[SYNC_STAGES-1];
    assign evt      = ~dir_q & ((pol_q & sync_val & ~prev_q) | (~pol_q & ~sync_val & prev_q));

    // Register updates; an edge event beats a same-cycle W1C clear
    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        en_d   = en_q;
        pol_d  = pol_q;
        clr    = '0;
        case (addr_q[4:2])
            REG_DATA: out_d = (out_q & ~wmask) | (wdata & wmask);
            REG_DIR:  dir_d = (dir_q & ~wmask) | (wdata & wmask);
            REG_EN:   en_d  = (en_q  & ~wmask) | (wdata & wmask);
            REG_POL:  pol_d = (pol_q & ~wmask) | (wdata & wmask);
            REG_STAT: clr   = wdata & wmask;
            default:  ;
        endcase
        stat_d = (stat_q & ~clr) | evt;
        prev_d = sync_val;
        sync_d = {sync_q[SYNC_STAGES-2:0], GPIOIN};
    end

    always_comb begin
        rdata = '0;
        if (addr_valid_q && !write_q) begin
            case (addr_q[4:2])
                REG_DATA: rdata = 32'((dir_q & out_q) | (~dir_q & sync_val));
                REG_DIR:  rdata = 32'(dir_q);
                REG_EN:   rdata = 32'(en_q);
                REG_POL:  rdata = 32'(pol_q);
                REG_STAT: rdata = 32'(stat_q);
                default:  rdata = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_valid_q <= 1'b0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            size_q       <= '0;
            out_q        <= '0;
            dir_q        <= '0;
            en_q         <= '0;
            pol_q        <= '0;
            stat_q       <= '0;
            prev_q       <= '0;
            sync_q       <= '0;
        end else begin
            addr_valid_q <= addr_valid_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            size_q       <= size_d;
            out_q        <= out_d;
            dir_q        <= dir_d;
            en_q         <= en_d;
            pol_q        <= pol_d;
            stat_q       <= stat_d;
            prev_q       <= prev_d;
            sync_q       <= sync_d;
        end
    end

    assign ahb.HRDATA    = rdata;
    assign ahb.HREADYOUT = 1'b1;
    assign GPIOOUT       = out_q;
    assign GPIODIR       = dir_q;
    assign GPIOIRQ       = |(stat_q & en_q);

    assign unused_ok = ^{ahb.HADDR[31:5], ahb.HTRANS[0], ahb.HWDATA, lane_mask};
endmodule

// File: tb/tb_ahb_gpio_param.sv
// Bench for ahb_gpio_param: directed plan items plus random traffic, checked by
// a queue scoreboard fed from a cycle-level reference model of the register map.
`timescale 1ns/1ps
module tb_ahb_gpio_param;
    localparam int unsigned W  = 16;
    localparam int unsigned SS = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] gpio_in, gpio_out, gpio_dir;
    logic         gpio_irq;

    always #5 clk = ~clk;

    ahb_gpio_param_if bus ();

    ahb_gpio_param #(.GPIO_WIDTH(W), .SYNC_STAGES(SS)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .ahb     (bus.slave),
        .GPIOIN  (gpio_in),
        .GPIOOUT (gpio_out),
        .GPIODIR (gpio_dir),
        .GPIOIRQ (gpio_irq)
    );

    typedef struct {
        string        nm;
        bit           chk_rd;
        logic [31:0]  rd;
        bit           chk_pins;
        logic [W-1:0] out;
        logic [W-1:0] dir;
        logic         irq;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic mon_go;

    // pending write handed from the driver to the model for the commit edge
    logic        pw_v;
    logic [31:0] pw_addr;
    logic [2:0]  pw_size;
    logic [31:0] pw_data;

    // reference model state
    logic [W-1:0] m_out, m_dir, m_en, m_pol, m_stat, m_prev;
    logic [W-1:0] hist[$];

    function automatic logic [W-1:0] lane_bits(input logic [4:0] a, input logic [2:0] sz);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            bit on;
            if (sz == 3'd0)      on = (b == int'(a[1:0]));
            else if (sz == 3'd1) on = ((b / 2) == int'(a[1]));
            else                 on = 1'b1;
            if (on) m[b*8 +: 8] = 8'hFF;
        end
        return m[W-1:0];
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [W-1:0] v;
        logic [W-1:0] s;
        s = hist[SS-1];
        v = '0;
        case (a[4:2])
            3'd0: for (int i = 0; i < W; i++) v[i] = m_dir[i] ? m_out[i] : s[i];
            3'd1: v = m_dir;
            3'd2: v = m_en;
            3'd3: v = m_pol;
            3'd4: v = m_stat;
            default: v = '0;
        endcase
        return 32'(v);
    endfunction

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_en = '0; m_pol = '0; m_stat = '0; m_prev = '0;
        hist.delete();
        for (int i = 0; i < int'(SS); i++) hist.push_back('0);
    endtask

    task automatic model_edge();
        logic [W-1:0] s, ev, clr, mk, dv;
        s   = hist[SS-1];
        clr = '0;
        for (int i = 0; i < W; i++)
            ev[i] = !m_dir[i] && (m_pol[i] ? (s[i] && !m_prev[i]) : (!s[i] && m_prev[i]));
        if (pw_v) begin
            mk = lane_bits(pw_addr[4:0], pw_size);
            dv = pw_data[W-1:0];
            case (pw_addr[4:2])
                3'd0: m_out = (m_out & ~mk) | (dv & mk);
                3'd1: m_dir = (m_dir & ~mk) | (dv & mk);
                3'd2: m_en  = (m_en  & ~mk) | (dv & mk);
                3'd3: m_pol = (m_pol & ~mk) | (dv & mk);
                3'd4: clr   = dv & mk;
                default: ;
            endcase
        end
        m_stat = (m_stat & ~clr) | ev;
        m_prev = s;
        hist.push_front(gpio_in);
        void'(hist.pop_back());
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_edge();
    end

    task automatic cmp(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s.%s got=%h want=%h t=%0t", nm, fld, got, want, $time);
        end
    endtask

    // monitor: one scoreboard entry per flagged data-phase cycle
    always @(negedge clk) begin
        if (mon_go) begin
            if (sb.size() == 0) begin
                cmp("scoreboard", "underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                cmp(e.nm, "hreadyout", 32'(bus.HREADYOUT), 32'd1);
                if (e.chk_rd) cmp(e.nm, "hrdata", bus.HRDATA, e.rd);
                if (e.chk_pins) begin
                    cmp(e.nm, "gpioout", 32'(gpio_out), 32'(e.out));
                    cmp(e.nm, "gpiodir", 32'(gpio_dir), 32'(e.dir));
                    cmp(e.nm, "gpioirq", 32'(gpio_irq), 32'(e.irq));
                end
            end
        end
    end

    function automatic exp_t mk(input string nm, input bit crd, input logic [31:0] rd,
                                input bit cp, input logic [W-1:0] o, input logic [W-1:0] d,
                                input logic q);
        exp_t e;
        e.nm = nm; e.chk_rd = crd; e.rd = rd; e.chk_pins = cp; e.out = o; e.dir = d; e.irq = q;
        return e;
    endfunction

    task automatic go(input exp_t e);
        sb.push_back(e);
        mon_go = 1'b1;
        @(posedge clk); #1;
        mon_go = 1'b0;
    endtask

    task automatic bus_idle();
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HSIZE = 3'd0;
        bus.HADDR = $urandom();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = w; bus.HADDR = a; bus.HSIZE = sz;
    endtask

    task automatic ahb_wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        addr_phase(a, 1'b1, sz);
        @(posedge clk); #1;
        bus_idle();
        bus.HWDATA = d;
        pw_addr = a; pw_size = sz; pw_data = d; pw_v = 1'b1;
        @(posedge clk); #1;
        pw_v = 1'b0;
    endtask

    task automatic rd_issue(input logic [31:0] a);
        addr_phase(a, 1'b0, $urandom_range(0, 2));
        @(posedge clk); #1;
        bus_idle();
        bus.HWDATA = $urandom();
    endtask

    task automatic rd_const(input logic [31:0] a, input logic [31:0] want, input string nm);
        rd_issue(a);
        go(mk(nm, 1'b1, want, 1'b0, '0, '0, 1'b0));
    endtask

    task automatic rd_model(input logic [31:0] a, input string nm);
        rd_issue(a);
        go(mk(nm, 1'b1, m_read(a[4:0]), 1'b1, m_out, m_dir, |(m_stat & m_en)));
    endtask

    task automatic snap_const(input string nm, input logic [W-1:0] o, input logic [W-1:0] d, input logic q);
        go(mk(nm, 1'b0, '0, 1'b1, o, d, q));
    endtask

    // write data phase overlapping the next read's address phase
    task automatic wr_rd(input logic [31:0] aw, input logic [2:0] sz, input logic [31:0] d,
                         input logic [31:0] ar, input string nm);
        addr_phase(aw, 1'b1, sz);
        @(posedge clk); #1;
        addr_phase(ar, 1'b0, 3'd2);
        bus.HWDATA = d;
        pw_addr = aw; pw_size = sz; pw_data = d; pw_v = 1'b1;
        @(posedge clk); #1;
        pw_v = 1'b0;
        bus_idle();
        go(mk(nm, 1'b1, m_read(ar[4:0]), 1'b1, m_out, m_dir, |(m_stat & m_en)));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish, got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; gpio_in = '0; mon_go = 1'b0; pw_v = 1'b0;
        pw_addr = '0; pw_size = '0; pw_data = '0;
        bus.HREADY = 1'b1; bus.HWDATA = '0;
        bus_idle();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset values
        snap_const("reset_pins", '0, '0, 1'b0);
        for (int a = 0; a < 8; a++) rd_const(32'(a * 4), 32'h0, $sformatf("reset_reg%0d", a));

        // mixed direction read-back
        ahb_wr(32'h04, 3'd2, 32'h0000_00FF);
        ahb_wr(32'h00, 3'd2, 32'h0000_A5A5);
        gpio_in = 16'h3C00;
        idle(3);
        rd_const(32'h00, 32'h0000_3CA5, "mixed_data");
        snap_const("mixed_pins", 16'hA5A5, 16'h00FF, 1'b0);

        // byte / halfword lanes and out-of-range bits
        ahb_wr(32'h00, 3'd2, 32'h0);
        ahb_wr(32'h01, 3'd0, 32'h0000_5A00);
        snap_const("byte_lane1", 16'h5A00, 16'h00FF, 1'b0);
        ahb_wr(32'h02, 3'd1, 32'h1234_0000);
        snap_const("upper_half_ignored", 16'h5A00, 16'h00FF, 1'b0);
        ahb_wr(32'h14, 3'd2, 32'hFFFF_FFFF);
        rd_const(32'h14, 32'h0, "reserved_reg");
        wr_rd(32'h08, 3'd2, 32'hFFFF_0042, 32'h08, "b2b_en");
        ahb_wr(32'h08, 3'd2, 32'h0);

        // rising-edge interrupt latency and W1C
        ahb_wr(32'h04, 3'd2, 32'h0);
        ahb_wr(32'h08, 3'd2, 32'h0100);
        ahb_wr(32'h0C, 3'd2, 32'h0100);
        gpio_in[8] = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= int'(SS) + 1; k++)
            snap_const($sformatf("irq_latency_e%0d", k), 16'h5A00, 16'h0000, (k == int'(SS) + 1));
        rd_const(32'h10, 32'h0000_0100, "stat_rise");
        ahb_wr(32'h10, 3'd2, 32'h0000_0100);
        snap_const("w1c_irq_low", 16'h5A00, 16'h0000, 1'b0);

        // falling edge, masking, set beats clear
        ahb_wr(32'h0C, 3'd2, 32'h0);
        ahb_wr(32'h08, 3'd2, 32'h0);
        gpio_in[3] = 1'b1;
        idle(4);
        gpio_in[3] = 1'b0;
        idle(4);
        rd_const(32'h10, 32'h0000_0008, "stat_fall");
        snap_const("fall_masked", 16'h5A00, 16'h0000, 1'b0);
        ahb_wr(32'h08, 3'd2, 32'h0008);
        snap_const("fall_enabled", 16'h5A00, 16'h0000, 1'b1);
        gpio_in[3] = 1'b1;
        idle(4);
        gpio_in[3] = 1'b0;
        idle(int'(SS) - 1);
        ahb_wr(32'h10, 3'd2, 32'h0000_0008);
        rd_const(32'h10, 32'h0000_0008, "set_beats_clear");
        snap_const("set_beats_clear_irq", 16'h5A00, 16'h0000, 1'b1);

        // reset during a write data phase
        addr_phase(32'h00, 1'b1, 3'd2);
        @(posedge clk); #1;
        bus_idle();
        bus.HWDATA = 32'h0000_FFFF;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        snap_const("rst_pins", '0, '0, 1'b0);
        idle(3);
        rd_const(32'h00, 32'h0000_3D00, "rst_data_sync");
        rd_const(32'h04, 32'h0, "rst_dir");
        rd_const(32'h10, 32'h0, "rst_stat");

        // random traffic against the model
        for (int it = 0; it < 300; it++) begin
            int unsigned op;
            logic [31:0] a, d;
            op = $urandom_range(0, 5);
            a  = $urandom();
            d  = $urandom();
            case (op)
                0: ahb_wr(a, 3'($urandom_range(0, 7)), d);
                1: rd_model(a, $sformatf("rnd_rd%0d", it));
                2: wr_rd(a, 3'($urandom_range(0, 7)), d, $urandom(), $sformatf("rnd_b2b%0d", it));
                3: begin
                    gpio_in = gpio_in ^ W'($urandom() & $urandom());
                    idle($urandom_range(1, 4));
                end
                4: begin
                    // bus activity that must not be accepted
                    bus.HSEL = $urandom_range(0, 1);
                    bus.HTRANS = bus.HSEL ? 2'($urandom_range(0, 1)) : 2'b10;
                    bus.HWRITE = 1'b1; bus.HADDR = a; bus.HSIZE = 3'd2;
                    @(posedge clk); #1;
                    bus_idle();
                    bus.HWDATA = d;
                    go(mk($sformatf("rnd_noise%0d", it), 1'b1, 32'h0, 1'b1, m_out, m_dir, |(m_stat & m_en)));
                end
                default: go(mk($sformatf("rnd_snap%0d", it), 1'b0, '0, 1'b1, m_out, m_dir, |(m_stat & m_en)));
            endcase
        end

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
